// File: rtl/monopix_tx_emu_if.sv
// Hit-side and DAQ-side signal bundle of the Monopix serial transmitter emulator.
// The master modport drives hits, FREEZE and READ; the slave modport is the emulator.
interface monopix_tx_emu_if #(
    parameter int WORD_BITS = 26
);
    logic                 HIT_WR;
    logic [WORD_BITS-1:0] HIT_DATA;
    logic                 FREEZE;
    logic                 READ;
    logic                 TOKEN;
    logic                 DATA;
    logic                 BUSY;
    logic [7:0]           OVF_CNT;
    logic [7:0]           RD_ERR_CNT;

    modport master (
        output HIT_WR, HIT_DATA, FREEZE, READ,
        input  TOKEN, DATA, BUSY, OVF_CNT, RD_ERR_CNT
    );

    modport slave (
        input  HIT_WR, HIT_DATA, FREEZE, READ,
        output TOKEN, DATA, BUSY, OVF_CNT, RD_ERR_CNT
    );
endinterface

// File: rtl/monopix_tx_emu.sv
// Monopix token/serial readout emulator: hit FIFO, freeze bookkeeping and a 26-bit MSB-first shifter.
// Define MONOPIX_TX_GRAY_EN to Gray-code the LE and TE fields when a word is loaded.
module monopix_tx_emu #(
    parameter int DEPTH     = 16,
    parameter int WORD_BITS = 26
) (
    input logic             CLK,
    input logic             RST,
    monopix_tx_emu_if.slave bus
);
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam logic [PTR_BITS:0]   OCC_FULL = (PTR_BITS + 1)'(DEPTH);
    localparam logic [PTR_BITS:0]   OCC_ONE  = (PTR_BITS + 1)'(1);
    localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
    localparam logic [4:0]          LAST_BIT = 5'(WORD_BITS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t               state, state_nxt;
    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
    logic [PTR_BITS:0]    occ, frozen_cnt, frozen_base, frozen_nxt;
    logic                 freeze_q;
    logic [WORD_BITS-1:0] hold_word, load_word, shreg, shreg_nxt;
    logic [4:0]           bit_cnt, bit_cnt_nxt;
    logic                 data_q, data_nxt, token_q, token_nxt;
    logic                 pop, push, ovf_hit, rd_err;
    logic [7:0]           ovf_cnt, rd_err_cnt;

    // A push at full still succeeds when the head leaves in the same cycle.
    // On the FREEZE rising edge the snapshot is the occupancy before this cycle's write.
    always_comb begin
        pop         = (state == IDLE) && bus.READ && (occ != '0);
        push        = bus.HIT_WR && ((occ != OCC_FULL) || pop);
        ovf_hit     = bus.HIT_WR && !push;
        rd_err      = bus.READ && !pop;
        frozen_base = (bus.FREEZE && !freeze_q) ? occ : frozen_cnt;
        frozen_nxt  = (pop && (frozen_base != '0)) ? frozen_base - OCC_ONE : frozen_base;
        if (bus.FREEZE) begin
            token_nxt = (frozen_base != '0) || (state != IDLE);
        end else begin
            token_nxt = (occ != '0) || (state != IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.HIT_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            frozen_cnt <= '0;
            freeze_q   <= 1'b0;
            hold_word  <= '0;
            token_q    <= 1'b0;
            ovf_cnt    <= '0;
            rd_err_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                hold_word <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
            frozen_cnt <= frozen_nxt;
            freeze_q   <= bus.FREEZE;
            token_q    <= token_nxt;
            if (ovf_hit && (ovf_cnt != 8'hFF)) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (rd_err && (rd_err_cnt != 8'hFF)) begin
                rd_err_cnt <= rd_err_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            data_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            data_q  <= data_nxt;
        end
    end

    // LOAD already drives the MSB so the first bit appears two cycles after READ.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        data_nxt    = 1'b0;
        load_word   = hold_word;
`ifdef MONOPIX_TX_GRAY_EN
        load_word[11:6] = hold_word[11:6] ^ {1'b0, hold_word[11:7]};
        load_word[5:0]  = hold_word[5:0] ^ {1'b0, hold_word[5:1]};
`endif
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt   = SHIFT;
                data_nxt    = load_word[WORD_BITS-1];
                shreg_nxt   = {load_word[WORD_BITS-2:0], 1'b0};
                bit_cnt_nxt = 5'd1;
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_nxt   = IDLE;
                    shreg_nxt   = '0;
                    bit_cnt_nxt = '0;
                end else begin
                    data_nxt    = shreg[WORD_BITS-1];
                    shreg_nxt   = {shreg[WORD_BITS-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.TOKEN      = token_q;
    assign bus.DATA       = data_q;
    assign bus.BUSY       = (state == SHIFT);
    assign bus.OVF_CNT    = ovf_cnt;
    assign bus.RD_ERR_CNT = rd_err_cnt;
endmodule

// File: tb/tb_monopix_tx_emu.sv
// Randomised bench for monopix_tx_emu, checked cycle by cycle against a queue-based model.
// The model tracks hits, the reader's busy window and the frozen hit set as plain numbers.
module tb_monopix_tx_emu;
    localparam int DEPTH = 16;
    localparam int WB    = 26;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    monopix_tx_emu_if #(.WORD_BITS(WB)) bus ();

    monopix_tx_emu #(.DEPTH(DEPTH), .WORD_BITS(WB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [WB-1:0] hit_q [$];
    logic [WB-1:0] cur_word;
    int n_cmp, n_fail;
    int cyc, busy_until, acc_edge;
    int ovf_m, rderr_m, frozen_m;
    logic frz_prev;

    // What the wire carries for a stored hit: LE/TE Gray-coded only in the Gray build.
    function automatic logic [WB-1:0] tx_image(input logic [WB-1:0] w);
        logic [WB-1:0] r;
        logic [5:0] le, te;
        r  = w;
        le = w[11:6];
        te = w[5:0];
`ifdef MONOPIX_TX_GRAY_EN
        r[11:6] = le ^ (le >> 1);
        r[5:0]  = te ^ (te >> 1);
`else
        r[11:6] = le;
        r[5:0]  = te;
`endif
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic clearModel();
        hit_q.delete();
        cyc        = 0;
        busy_until = 0;
        acc_edge   = -100;
        ovf_m      = 0;
        rderr_m    = 0;
        frozen_m   = 0;
        frz_prev   = 1'b0;
    endtask

    // One clock: drive at the falling edge, advance the model, compare after the rising edge.
    task automatic applyStimulus(input logic wr, input logic [WB-1:0] d, input logic frz, input logic rd);
        logic idle, pop, tok_exp, data_exp, busy_exp;
        int occ, snap, k;
        @(negedge CLK);
        bus.HIT_WR   = wr;
        bus.HIT_DATA = d;
        bus.FREEZE   = frz;
        bus.READ     = rd;
        idle    = (cyc >= busy_until);
        occ     = hit_q.size();
        pop     = rd && idle && (occ != 0);
        snap    = (frz && !frz_prev) ? occ : frozen_m;
        tok_exp = frz ? ((snap != 0) || !idle) : ((occ != 0) || !idle);
        if (pop) begin
            cur_word   = tx_image(hit_q.pop_front());
            acc_edge   = cyc;
            busy_until = cyc + 28;
        end else if (rd && rderr_m < 255) begin
            rderr_m++;
        end
        if (wr) begin
            if (hit_q.size() < DEPTH) hit_q.push_back(d);
            else if (ovf_m < 255) ovf_m++;
        end
        frozen_m = (pop && snap != 0) ? snap - 1 : snap;
        frz_prev = frz;
        k        = cyc - acc_edge;
        busy_exp = (k >= 1 && k <= 26);
        data_exp = busy_exp ? cur_word[26-k] : 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("token", 8'(bus.TOKEN), 8'(tok_exp));
        checkOutput("data", 8'(bus.DATA), 8'(data_exp));
        checkOutput("busy", 8'(bus.BUSY), 8'(busy_exp));
        checkOutput("ovf_cnt", bus.OVF_CNT, 8'(ovf_m));
        checkOutput("rd_err_cnt", bus.RD_ERR_CNT, 8'(rderr_m));
        cyc++;
    endtask

    // Reset may land mid-cycle; outputs must drop before any clock edge.
    task automatic doReset();
        @(posedge CLK);
        #3;
        bus.HIT_WR   = 1'b0;
        bus.HIT_DATA = '0;
        bus.FREEZE   = 1'b0;
        bus.READ     = 1'b0;
        RST          = 1'b1;
        #1;
        checkOutput("rst_token", 8'(bus.TOKEN), 8'd0);
        checkOutput("rst_data", 8'(bus.DATA), 8'd0);
        checkOutput("rst_busy", 8'(bus.BUSY), 8'd0);
        checkOutput("rst_ovf", bus.OVF_CNT, 8'd0);
        checkOutput("rst_rderr", bus.RD_ERR_CNT, 8'd0);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        clearModel();
    endtask

    task automatic drainAll(input logic frz);
        int guard;
        guard = 0;
        while ((hit_q.size() != 0 || cyc < busy_until) && guard < 3000) begin
            applyStimulus(1'b0, '0, frz, cyc >= busy_until);
            guard++;
        end
        if (guard >= 3000) checkOutput("drain_bound", 8'd1, 8'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clearModel();
        doReset();

        // Single known word, read once.
        applyStimulus(1'b1, 26'h2A55A5A, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("token_before_read", 8'(bus.TOKEN), 8'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (30) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("token_after_word", 8'(bus.TOKEN), 8'd0);

        // Overflow by three, then drain in order.
        doReset();
        for (int i = 0; i < DEPTH + 3; i++) applyStimulus(1'b1, 26'($urandom()), 1'b0, 1'b0);
        checkOutput("ovf_three", bus.OVF_CNT, 8'd3);
        drainAll(1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("token_drained", 8'(bus.TOKEN), 8'd0);

        // Frozen set of three with two late hits.
        doReset();
        repeat (3) applyStimulus(1'b1, 26'($urandom()), 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b1, 26'($urandom()), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b1);
            repeat (28) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkOutput("token_frozen_done", 8'(bus.TOKEN), 8'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("token_unfrozen", 8'(bus.TOKEN), 8'd1);
        drainAll(1'b0);

        // READ during SHIFT and READ on an empty FIFO.
        doReset();
        applyStimulus(1'b1, 26'($urandom()), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (8) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (25) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("rderr_two", bus.RD_ERR_CNT, 8'd2);

        // Reset partway through a word; the stored second hit must be gone.
        doReset();
        repeat (2) applyStimulus(1'b1, 26'($urandom()), 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        doReset();
        repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("rderr_after_abort", bus.RD_ERR_CNT, 8'd1);

        // Full FIFO with simultaneous write and read.
        doReset();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 26'($urandom()), 1'b0, 1'b0);
        applyStimulus(1'b1, 26'($urandom()), 1'b0, 1'b1);
        applyStimulus(1'b1, 26'($urandom()), 1'b0, 1'b0);
        checkOutput("ovf_after_full_rw", bus.OVF_CNT, 8'd1);
        drainAll(1'b0);

        // Random traffic with freeze toggling and saturating counters.
        doReset();
        begin
            logic frz;
            frz = 1'b0;
            for (int i = 0; i < 2500; i++) begin
                if ($urandom_range(39) == 0) frz = ~frz;
                applyStimulus($urandom_range(2) == 0, 26'($urandom()), frz, $urandom_range(3) == 0);
            end
        end
        drainAll(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/monopix_tx_emu.md
MONOPIX_TX_EMU -- requirements
Module: monopix_tx_emu

Interface
REQ-001 Parameter DEPTH, default 16, hit FIFO depth; SHALL be a power of two, 4..64.
REQ-002 Parameter WORD_BITS, default 26, serial word length {COL[5:0], ROW[7:0], LE[5:0], TE[5:0]}, fixed.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 CLK  in  1  chip readout clock (CLK40 domain); all logic on rising edge.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 HIT_WR  in  1  push HIT_DATA into hit FIFO.
REQ-007 HIT_DATA  in  26  hit word to enqueue.
REQ-008 FREEZE  in  1  from DAQ receiver; freezes the current hit set.
REQ-009 READ  in  1  from DAQ receiver; one-cycle pulse requests the next hit.
REQ-010 TOKEN  out  1  hits pending, registered.
REQ-011 DATA  out  1  serial hit data, MSB first, registered.
REQ-012 BUSY  out  1  shift in progress.
REQ-013 OVF_CNT  out  8  dropped-hit counter, saturating.
REQ-014 RD_ERR_CNT  out  8  ignored-READ counter, saturating.

Function
REQ-015 The hit FIFO SHALL accept HIT_WR when not full; HIT_WR when full SHALL drop the word and increment OVF_CNT, saturating at 255.
REQ-016 TOKEN SHALL be high one cycle after FIFO becomes non-empty and SHALL be low one cycle after FIFO empty and FSM in IDLE.
REQ-017 On FREEZE rising edge, FROZEN_CNT SHALL latch the FIFO occupancy; hits written while FREEZE is high SHALL be stored but not counted in the frozen set.
REQ-018 While FREEZE is high, TOKEN SHALL reflect FROZEN_CNT != 0 or FSM not IDLE; after FREEZE falls, TOKEN SHALL revert to REQ-016.
REQ-019 FSM states: IDLE, LOAD, SHIFT.
REQ-020 IDLE -> LOAD on READ=1 with FIFO non-empty; the FIFO head SHALL be popped in that cycle and FROZEN_CNT decremented if nonzero.
REQ-021 LOAD -> SHIFT after one cycle; shift register loaded, BUSY=1.
REQ-022 SHIFT: DATA SHALL present bit 25 first, one bit per cycle, 26 cycles; return to IDLE after the 26th bit, BUSY=0 in the same cycle as IDLE is entered.
REQ-023 Latency: first data bit on DATA exactly 2 cycles after the READ cycle.
REQ-024 READ in LOAD or SHIFT, or READ with FIFO empty, SHALL be ignored and increment RD_ERR_CNT, saturating at 255.
REQ-025 DATA SHALL be 0 outside SHIFT.
REQ-026 HIT_WR and pop in the same cycle at full SHALL both succeed; occupancy unchanged, no overflow counted.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; occupancy held in log2(DEPTH)+1 bits.

Reset
REQ-028 RST SHALL asynchronously clear FIFO, FROZEN_CNT, counters and shift register, force IDLE, and drive TOKEN=0, DATA=0, BUSY=0.
REQ-029 RST asserted mid-shift SHALL abort the word; no partial word SHALL resume after release.
REQ-030 First HIT_WR SHALL be honoured on the first rising edge after RST deasserts.

Configuration
REQ-031 Macro MONOPIX_TX_GRAY_EN: when defined, LE and TE fields SHALL be converted binary-to-Gray at LOAD before shifting; when undefined, LE and TE are shifted unmodified; COL and ROW are never converted.

Verification
REQ-032 Push 0x2A5_5A5A, READ pulse -> TOKEN=1 before READ; DATA bits 2..27 cycles after READ = 26'h2A55A5A MSB first (LE/TE Gray-coded when macro defined); TOKEN=0 afterwards.
REQ-033 Push DEPTH+3 words with no READ -> OVF_CNT=3; read all -> exactly DEPTH words out, in order.
REQ-034 Push 3 hits, FREEZE=1, push 2 more, 3 READs -> TOKEN low after third word while FREEZE high; FREEZE=0 -> TOKEN high within 1 cycle.
REQ-035 READ during SHIFT and READ with FIFO empty -> RD_ERR_CNT=2, output word uncorrupted.
REQ-036 RST at bit 10 of shift -> DATA=0, BUSY=0, TOKEN=0 immediately; FIFO empty after release.
REQ-037 Full FIFO, simultaneous HIT_WR and READ -> occupancy stays DEPTH, OVF_CNT unchanged.
